// File: rtl/paddle_emu.sv
// paddle_emu: emulates two Atari 2600 paddle pots (TIA INPT0/INPT1) from USB HID
// analog axes. Each paddle position is a scanline count; after the TIA releases
// its dump transistor the pot line reads high once that many lines have passed.
// Optional feature macro: PADDLE_MOUSE_EN adds relative mouse steering of paddle 0.
module paddle_emu #(
    parameter logic [7:0] MAX_POS = 8'd228,
    parameter bit         INVERT  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_tick,
    input  logic              dump,
    input  logic              joystick_strobe,
    input  logic signed [7:0] joystick0ax,
    input  logic signed [7:0] joystick1ax,
    input  logic [7:0]        joystick0,
    input  logic [7:0]        joystick1,
`ifdef PADDLE_MOUSE_EN
    input  logic              mouse_mode,
    input  logic              mouse_strobe,
    input  logic signed [7:0] mouse_dx,
`endif
    output logic [1:0]        pot,
    output logic [1:0]        paddle_btn_n,
    output logic [7:0]        pos0,
    output logic [7:0]        pos1
);

    localparam int DATA_W = 8;

    localparam logic [1:0] ST_DUMP   = 2'd0;
    localparam logic [1:0] ST_CHARGE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Map a signed axis onto 0..MAX_POS: offset-binary, then scale by MAX_POS/256.
    function automatic logic [DATA_W-1:0] scale_axis(input logic signed [DATA_W-1:0] ax);
        logic [DATA_W-1:0]   u;
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   s;
        u    = {~ax[DATA_W-1], ax[DATA_W-2:0]};
        prod = {{DATA_W{1'b0}}, u} * {{DATA_W{1'b0}}, MAX_POS};
        s    = prod[2*DATA_W-1:DATA_W];
        if (INVERT) begin
            s = MAX_POS - s;
        end
        return s;
    endfunction

`ifdef PADDLE_MOUSE_EN
    // Saturate a 10-bit signed position sum into 0..MAX_POS.
    function automatic logic [DATA_W-1:0] clamp_pos(input logic signed [DATA_W+1:0] v);
        logic [DATA_W-1:0] r;
        if (v < 10'sd0) begin
            r = '0;
        end else if (v > $signed({2'b00, MAX_POS})) begin
            r = MAX_POS;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    logic signed [DATA_W+1:0] mouse_sum;
    assign mouse_sum = $signed({2'b00, pos0}) + $signed({{2{mouse_dx[DATA_W-1]}}, mouse_dx});
`endif

    // Only bit 4 (fire) of each HID joystick byte is meaningful here.
    logic unused_joy_bits;
    assign unused_joy_bits = ^{joystick0[7:5], joystick0[3:0], joystick1[7:5], joystick1[3:0]};

    logic [DATA_W-1:0] pos_sel [2];
    logic [1:0]        state   [2];
    logic [DATA_W-1:0] cnt     [2];
    logic [DATA_W-1:0] tgt     [2];

    assign pos_sel[0] = pos0;
    assign pos_sel[1] = pos1;

    // Paddle position registers, updated the cycle after a data strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos0 <= MAX_POS >> 1;
            pos1 <= MAX_POS >> 1;
        end else begin
`ifdef PADDLE_MOUSE_EN
            if (mouse_mode) begin
                if (mouse_strobe) begin
                    pos0 <= clamp_pos(mouse_sum);
                end
            end else if (joystick_strobe) begin
                pos0 <= scale_axis(joystick0ax);
            end
`else
            if (joystick_strobe) begin
                pos0 <= scale_axis(joystick0ax);
            end
`endif
            if (joystick_strobe) begin
                pos1 <= scale_axis(joystick1ax);
            end
        end
    end

    // Fire buttons: registered and inverted to active-low for the RIOT port.
    always_ff @(posedge clk) begin
        if (reset) begin
            paddle_btn_n <= 2'b11;
        end else begin
            paddle_btn_n <= ~{joystick1[4], joystick0[4]};
        end
    end

    // Charge targets are latched when the dump releases so mid-charge moves wait a frame.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!dump && state[i] == ST_DUMP) begin
                tgt[i] <= pos_sel[i];
            end
        end
    end

    // Per-paddle capacitor FSM: grounded, counting scanlines, then charged.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= ST_DUMP;
                cnt[i]   <= '0;
                pot[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (dump) begin
                    state[i] <= ST_DUMP;
                    cnt[i]   <= '0;
                    pot[i]   <= 1'b0;
                end else begin
                    case (state[i])
                        ST_DUMP: begin
                            state[i] <= ST_CHARGE;
                            cnt[i]   <= '0;
                            pot[i]   <= 1'b0;
                        end
                        ST_CHARGE: begin
                            if (cnt[i] >= tgt[i]) begin
                                state[i] <= ST_DONE;
                                pot[i]   <= 1'b1;
                            end else if (line_tick && cnt[i] != 8'hFF) begin
                                cnt[i] <= cnt[i] + 8'd1;
                            end
                        end
                        ST_DONE: begin
                            pot[i] <= 1'b1;
                        end
                        default: begin
                            state[i] <= ST_DUMP;
                            cnt[i]   <= '0;
                            pot[i]   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_emu.sv
// Testbench for paddle_emu (default build, mouse feature disabled).
module tb_paddle_emu;

    localparam int MAX = 228;

    logic       clk;
    logic       reset;
    logic       line_tick;
    logic       dump;
    logic       joystick_strobe;
    logic [7:0] joystick0ax;
    logic [7:0] joystick1ax;
    logic [7:0] joystick0;
    logic [7:0] joystick1;
    logic [1:0] pot;
    logic [1:0] paddle_btn_n;
    logic [7:0] pos0;
    logic [7:0] pos1;

    int total = 0;
    int bad   = 0;
    int cur0;
    int cur1;

    paddle_emu dut (
        .clk             (clk),
        .reset           (reset),
        .line_tick       (line_tick),
        .dump            (dump),
        .joystick_strobe (joystick_strobe),
        .joystick0ax     (joystick0ax),
        .joystick1ax     (joystick1ax),
        .joystick0       (joystick0),
        .joystick1       (joystick1),
        .pot             (pot),
        .paddle_btn_n    (paddle_btn_n),
        .pos0            (pos0),
        .pos1            (pos1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Axis value -128..127 maps linearly onto 0..MAX scanlines (floor).
    function automatic int model_pos(input logic [7:0] ax);
        int v;
        v = int'($signed(ax)) + 128;
        return (v * MAX) / 256;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_axes(input logic [7:0] a0, input logic [7:0] a1);
        joystick0ax     = a0;
        joystick1ax     = a1;
        joystick_strobe = 1'b1;
        step();
        joystick_strobe = 1'b0;
        cur0 = model_pos(a0);
        cur1 = model_pos(a1);
        check("pos0_strobe", pos0, cur0);
        check("pos1_strobe", pos1, cur1);
    endtask

    // One frame: ground the caps, release, then feed random scanline ticks. A paddle
    // reads charged on the cycle after the tick count seen so far reaches its target.
    task automatic run_frame(input bit rel_strobe, input logic [7:0] r0, input logic [7:0] r1,
                             input bit mid);
        int t0, t1, ticks, prev;
        bit done, lt;
        logic [7:0] m0, m1;
        logic [1:0] exp_pot;
        t0 = cur0;
        t1 = cur1;
        ticks = 0;
        done = 1'b0;
        m0 = 8'h00;
        m1 = 8'h00;
        dump = 1'b1;
        step();
        step();
        check("pot_dumped", pot, 0);
        dump = 1'b0;
        if (rel_strobe) begin
            joystick0ax     = r0;
            joystick1ax     = r1;
            joystick_strobe = 1'b1;
        end
        step();
        joystick_strobe = 1'b0;
        check("pot_release", pot, 0);
        if (rel_strobe) begin
            cur0 = model_pos(r0);
            cur1 = model_pos(r1);
            check("pos0_rel_strobe", pos0, cur0);
            check("pos1_rel_strobe", pos1, cur1);
        end
        for (int c = 0; c < 1500 && !done; c++) begin
            lt = 1'($urandom_range(0, 1));
            line_tick = lt;
            if (mid && c == 3) begin
                m0 = 8'($urandom);
                m1 = 8'($urandom);
                joystick0ax     = m0;
                joystick1ax     = m1;
                joystick_strobe = 1'b1;
            end
            step();
            line_tick       = 1'b0;
            joystick_strobe = 1'b0;
            prev  = ticks;
            ticks = ticks + int'(lt);
            exp_pot = {prev >= t1, prev >= t0};
            check("pot_charge", pot, exp_pot);
            if (mid && c == 3) begin
                cur0 = model_pos(m0);
                cur1 = model_pos(m1);
                check("pos0_mid", pos0, cur0);
                check("pos1_mid", pos1, cur1);
            end
            if (prev >= t0 && prev >= t1) done = 1'b1;
        end
        total++;
        assert (done) else begin
            bad++;
            $error("FAIL frame_timeout observed=%0d expected=%0d", ticks, (t0 > t1) ? t0 : t1);
        end
    endtask

    initial begin
        reset           = 1'b1;
        dump            = 1'b1;
        line_tick       = 1'b0;
        joystick_strobe = 1'b0;
        joystick0ax     = 8'h00;
        joystick1ax     = 8'h00;
        joystick0       = 8'h00;
        joystick1       = 8'h00;
        cur0 = MAX / 2;
        cur1 = MAX / 2;
        step();
        step();
        step();
        check("reset_pot", pot, 0);
        check("reset_btn", paddle_btn_n, 2'b11);
        check("reset_pos0", pos0, 114);
        check("reset_pos1", pos1, 114);
        reset = 1'b0;
        step();

        // Default positions: both paddles charge after 114 lines.
        run_frame(1'b0, 8'h00, 8'h00, 1'b0);

        // Extremes: full left gives an immediate charge, full right 227 lines.
        set_axes(8'h80, 8'h7F);
        check("pos0_min", pos0, 0);
        check("pos1_max", pos1, 227);
        run_frame(1'b0, 8'h00, 8'h00, 1'b0);
        set_axes(8'h80, 8'h00);
        check("pos1_center", pos1, 114);

        // Abort a 200-line charge after 50 lines, then the full count must restart.
        set_axes(8'h61, 8'h61);
        dump = 1'b1;
        step();
        dump = 1'b0;
        step();
        line_tick = 1'b1;
        for (int k = 0; k < 50; k++) step();
        line_tick = 1'b0;
        check("pot_mid_charge", pot, 0);
        dump = 1'b1;
        step();
        check("pot_abort", pot, 0);
        run_frame(1'b0, 8'h00, 8'h00, 1'b0);

        // Strobe coincident with dump release: this frame uses old 114, next uses 20.
        set_axes(8'h00, 8'h00);
        run_frame(1'b1, 8'h97, 8'h97, 1'b0);
        check("pos0_new20", pos0, 20);
        run_frame(1'b0, 8'h00, 8'h00, 1'b0);

        // Random positions, with random moves during the charge that must not disturb it.
        for (int n = 0; n < 6; n++) begin
            set_axes(8'($urandom), 8'($urandom));
            run_frame(1'b0, 8'h00, 8'h00, 1'b1);
        end

        // Fire buttons.
        for (int n = 0; n < 6; n++) begin
            joystick0 = 8'($urandom);
            joystick1 = 8'($urandom);
            step();
            check("btn", paddle_btn_n, {~joystick1[4], ~joystick0[4]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
